// File: rtl/mpu_tx_pkg.sv
// Shared types and constants for the MPU result transmitter.
// Used by mpu_octet_packer and mpu_frame_tx_gen.
package mpu_tx_pkg;

  // Value carried in the TYPE octet of every frame.
  typedef enum logic [7:0] {
    FRAME_DATA      = 8'h01,
    FRAME_ERR_DIM   = 8'h02,
    FRAME_ERR_CMD   = 8'h03,
    FRAME_ERR_FRAME = 8'h04
  } frame_type_t;

  // Octet engine sequencing: header, payload, optional pad, end-of-frame.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAY,
    ST_PAD,
    ST_END
  } tx_state_t;

  localparam int HDR_OCTETS = 18;
  localparam int MIN_FRAME  = 60;

  // Number of elements carried by the next frame of a (possibly split) result.
  function automatic logic [15:0] frame_elems(input logic [15:0] remaining,
                                              input int max_elems);
    return (remaining > 16'(max_elems)) ? 16'(max_elems) : remaining;
  endfunction

endpackage

// File: rtl/mpu_octet_packer.sv
// Gathers a byte stream into Avalon-ST words, first octet in the MSB byte.
// A frame's last octet closes its word early, so frames never share a word.
module mpu_octet_packer
  import mpu_tx_pkg::*;
#(
  parameter  int OUT_WIDTH = 32,
  localparam int EMPTY_W   = (OUT_WIDTH > 8) ? $clog2(OUT_WIDTH / 8) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 oct_valid,
  input  logic [7:0]           oct_data,
  input  logic                 oct_last,
  output logic                 oct_ready,
  output logic [OUT_WIDTH-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 tx_sop,
  output logic                 tx_eop,
  output logic [EMPTY_W-1:0]   tx_empty,
  output logic                 idle
);

  localparam int BYTES = OUT_WIDTH / 8;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [OUT_WIDTH-1:0] acc_data;
  logic [CW-1:0]        acc_cnt;
  logic                 acc_sop;
  logic                 first_pending;
  logic                 out_free;
  logic                 word_done;
  logic [OUT_WIDTH-1:0] merged;

  assign out_free  = !tx_valid || tx_ready;
  assign word_done = oct_last || (acc_cnt == CW'(BYTES - 1));
  // Only an octet that completes a word needs the output register to be free.
  assign oct_ready = out_free || !word_done;
  assign idle      = !tx_valid && (acc_cnt == '0);

  // Partial word with the incoming octet dropped into its lane.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    merged = acc_data;
    for (int b = 0; b < BYTES; b++) begin
      if (acc_cnt == CW'(b)) merged[OUT_WIDTH-1-8*b -: 8] = oct_data;
    end
  end

  // Accumulate octets and hand finished words to the held output register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    if (rst) begin
      acc_data      <= '0;
      acc_cnt       <= '0;
      acc_sop       <= 1'b0;
      first_pending <= 1'b1;
      tx_data       <= '0;
      tx_valid      <= 1'b0;
      tx_sop        <= 1'b0;
      tx_eop        <= 1'b0;
      tx_empty      <= '0;
    end else begin
      if (tx_valid && tx_ready) tx_valid <= 1'b0;
      if (oct_valid && oct_ready) begin
        first_pending <= oct_last;
        if (word_done) begin
          tx_data  <= merged;
          tx_valid <= 1'b1;
          tx_sop   <= (acc_cnt == '0) ? first_pending : acc_sop;
          tx_eop   <= oct_last;
          tx_empty <= oct_last ? EMPTY_W'(BYTES - 1 - int'(acc_cnt)) : '0;
          acc_data <= '0;
          acc_cnt  <= '0;
          acc_sop  <= 1'b0;
        end else begin
          acc_data <= merged;
          acc_cnt  <= acc_cnt + 1'b1;
          if (acc_cnt == '0) acc_sop <= first_pending;
        end
      end
    end
  end

endmodule

// File: rtl/mpu_frame_tx_gen.sv
// MPU result transmitter: turns a result element stream into one or more
// MPU frames (header + big-endian sign-extended payload) on Avalon-ST.
// Optional build macro MPU_TX_PAD_EN zero-pads short frames to 60 octets.
module mpu_frame_tx_gen
  import mpu_tx_pkg::*;
#(
  parameter  int          OUT_WIDTH = 32,
  parameter  int          ACC_SIZE  = 24,
  parameter  int          MAX_ELEMS = 368,
  parameter  logic [47:0] MAC_MPU   = 48'h02_00_00_00_00_01,
  localparam int          EMPTY_W   = (OUT_WIDTH > 8) ? $clog2(OUT_WIDTH / 8) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           dim_x,
  input  logic [7:0]           dim_y,
  input  logic                 dim_error,
  input  logic [7:0]           rx_error,
  input  logic [47:0]          host_mac,
  input  logic [ACC_SIZE-1:0]  res_data,
  input  logic                 res_valid,
  output logic                 res_ready,
  output logic [OUT_WIDTH-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 tx_sop,
  output logic                 tx_eop,
  output logic [EMPTY_W-1:0]   tx_empty,
  output logic                 tx_idle
);

  tx_state_t   state;
  frame_type_t ftype_q;
  logic [47:0] host_mac_q;
  logic [7:0]  dx_q, dy_q;
  logic [15:0] remaining;   // elements of the result not yet assigned to a frame
  logic [15:0] n_q;         // elements in the current frame
  logic [15:0] load_left;   // elements of the current frame not yet loaded
  logic [15:0] oct_cnt;     // octet index within the current frame
  logic [31:0] hold_data;
  logic        hold_full;
  logic [1:0]  bsel;

  frame_type_t start_type;
  logic [15:0] start_total;
  logic [15:0] next_n;
  logic [15:0] len_field, frame_len, total_len;
  logic [143:0] hdr;
  logic        oct_valid, oct_ready, oct_last, oct_fire;
  logic [7:0]  oct_data;
  logic        res_fire;
  logic        packer_idle;

  // Classify a new request; rx errors outrank dimension errors.
  always_comb begin
    start_type  = FRAME_DATA;
    start_total = '0;
    if (rx_error != 8'h00) begin
      start_type = FRAME_ERR_FRAME;
    end else if (dim_error || (dim_x == 8'h00) || (dim_y == 8'h00)) begin
      start_type = FRAME_ERR_DIM;
    end else begin
      start_total = 16'(dim_x) * 16'(dim_y);
    end
  end

  assign next_n    = frame_elems((state == ST_IDLE) ? start_total : remaining, MAX_ELEMS);
  assign len_field = 16'd4 + (n_q << 2);
  assign frame_len = 16'(HDR_OCTETS) + (n_q << 2);
`ifdef MPU_TX_PAD_EN
  assign total_len = (frame_len < 16'(MIN_FRAME)) ? 16'(MIN_FRAME) : frame_len;
`else
  assign total_len = frame_len;
`endif
  assign hdr = {host_mac_q, MAC_MPU, len_field, ftype_q, dx_q, dy_q, 8'h00};

  // Octet engine: pick the octet for the current frame position.
  always_comb begin
    oct_valid = 1'b0;
    oct_data  = 8'h00;
    case (state)
      ST_HDR: begin
        oct_valid = 1'b1;
        for (int i = 0; i < HDR_OCTETS; i++) begin
          if (oct_cnt[4:0] == 5'(i)) oct_data = hdr[143-8*i -: 8];
        end
      end
      ST_PAY: begin
        oct_valid = hold_full;
        case (bsel)
          2'd0:    oct_data = hold_data[31:24];
          2'd1:    oct_data = hold_data[23:16];
          2'd2:    oct_data = hold_data[15:8];
          default: oct_data = hold_data[7:0];
        endcase
      end
`ifdef MPU_TX_PAD_EN
      ST_PAD: oct_valid = 1'b1;
`endif
      default: oct_valid = 1'b0;
    endcase
  end

  assign oct_last = (oct_cnt == total_len - 16'd1);
  assign oct_fire = oct_valid && oct_ready;
  // The holding register counts as empty on the cycle its last octet leaves,
  // so back-to-back elements stream without a gap.
  assign res_ready = (state == ST_PAY) && (load_left != 16'd0) &&
                     (!hold_full || (oct_fire && (bsel == 2'd3)));
  assign res_fire  = res_valid && res_ready;
  assign tx_idle   = (state == ST_IDLE) && packer_idle;

  // Frame sequencer, element holding register and per-frame counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ftype_q    <= FRAME_DATA;
      host_mac_q <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      remaining  <= '0;
      n_q        <= '0;
      load_left  <= '0;
      oct_cnt    <= '0;
      hold_data  <= '0;
      hold_full  <= 1'b0;
      bsel       <= '0;
    end else begin
      if (res_fire) begin
        hold_data <= 32'($signed(res_data));
        hold_full <= 1'b1;
        load_left <= load_left - 16'd1;
      end else if (oct_fire && (state == ST_PAY) && (bsel == 2'd3)) begin
        hold_full <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (start && packer_idle) begin
            ftype_q    <= start_type;
            host_mac_q <= host_mac;
            dx_q       <= dim_x;
            dy_q       <= dim_y;
            n_q        <= next_n;
            load_left  <= next_n;
            remaining  <= start_total - next_n;
            oct_cnt    <= '0;
            bsel       <= '0;
            state      <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (oct_fire) begin
            oct_cnt <= oct_cnt + 16'd1;
            if (oct_last) begin
              state <= ST_END;
            end else if (oct_cnt == 16'(HDR_OCTETS - 1)) begin
`ifdef MPU_TX_PAD_EN
              state <= (n_q != 16'd0) ? ST_PAY : ST_PAD;
`else
              state <= ST_PAY;
`endif
            end
          end
        end
        ST_PAY: begin
          if (oct_fire) begin
            oct_cnt <= oct_cnt + 16'd1;
            bsel    <= bsel + 2'd1;
            if (oct_last) state <= ST_END;
`ifdef MPU_TX_PAD_EN
            else if (oct_cnt == frame_len - 16'd1) state <= ST_PAD;
`endif
          end
        end
`ifdef MPU_TX_PAD_EN
        ST_PAD: begin
          if (oct_fire) begin
            oct_cnt <= oct_cnt + 16'd1;
            if (oct_last) state <= ST_END;
          end
        end
`endif
        ST_END: begin
          if (remaining != 16'd0) begin
            n_q       <= next_n;
            load_left <= next_n;
            remaining <= remaining - next_n;
            oct_cnt   <= '0;
            bsel      <= '0;
            state     <= ST_HDR;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mpu_octet_packer #(.OUT_WIDTH(OUT_WIDTH)) u_packer (
    .clk       (clk),
    .rst       (rst),
    .oct_valid (oct_valid),
    .oct_data  (oct_data),
    .oct_last  (oct_last),
    .oct_ready (oct_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_sop    (tx_sop),
    .tx_eop    (tx_eop),
    .tx_empty  (tx_empty),
    .idle      (packer_idle)
  );

endmodule

// File: tb/tb_mpu_frame_tx_gen.sv
// Self-checking bench for mpu_frame_tx_gen (OUT_WIDTH=32, ACC_SIZE=24).
// Frames are predicted octet by octet from the frame layout rules and
// packed into expected words; literal checks pin key words of that model.
module tb_mpu_frame_tx_gen;

  localparam int          W       = 32;
  localparam int          B       = W / 8;
  localparam int          MAXE    = 368;
  localparam logic [47:0] SRC_MAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] HOST    = 48'hA1_B2_C3_D4_E5_F6;
`ifdef MPU_TX_PAD_EN
  localparam int PAD_TO = 60;
`else
  localparam int PAD_TO = 0;
`endif

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
    logic [31:0] data;
  } word_t;

  logic        clk, rst, start, dim_error, res_valid, res_ready;
  logic        tx_valid, tx_ready, tx_sop, tx_eop, tx_idle;
  logic [7:0]  dim_x, dim_y, rx_error;
  logic [47:0] host_mac;
  logic [23:0] res_data;
  logic [31:0] tx_data;
  logic [1:0]  tx_empty;

  word_t       exp_q[$];
  word_t       rx_words[$];
  word_t       t3_words[$];
  logic [23:0] elem_q[$];
  logic [23:0] elems_in[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          ready_pct = 100;

  mpu_frame_tx_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dim_x     (dim_x),
    .dim_y     (dim_y),
    .dim_error (dim_error),
    .rx_error  (rx_error),
    .host_mac  (host_mac),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_sop    (tx_sop),
    .tx_eop    (tx_eop),
    .tx_empty  (tx_empty),
    .tx_idle   (tx_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic word_t rx_at(input int i);
    if (i < rx_words.size()) return rx_words[i];
    return '0;
  endfunction

  // Words a frame of the given unpadded octet count occupies on the bus.
  function automatic int exp_words(input int octs);
    int t = (octs < PAD_TO) ? PAD_TO : octs;
    return (t + B - 1) / B;
  endfunction

  function automatic int exp_empty(input int octs);
    int t = (octs < PAD_TO) ? PAD_TO : octs;
    return exp_words(octs) * B - t;
  endfunction

  // Reference model: build every frame of a result as an octet list, then pack.
  task automatic model_push(input logic [7:0] dx, input logic [7:0] dy,
                            input logic de, input logic [7:0] rxe);
    logic [7:0]  oct[$];
    logic [47:0] src = SRC_MAC;
    logic [31:0] v;
    int typ, total, rem, n, k, len, s, nw;
    k = 0;
    if (rxe != 0)                      begin typ = 4; total = 0; end
    else if (de || dx == 0 || dy == 0) begin typ = 2; total = 0; end
    else                               begin typ = 1; total = dx * dy; end
    rem = total;
    do begin
      n   = (rem > MAXE) ? MAXE : rem;
      rem = rem - n;
      len = 4 + 4 * n;
      oct.delete();
      for (int i = 0; i < 6; i++) oct.push_back(HOST[47-8*i -: 8]);
      for (int i = 0; i < 6; i++) oct.push_back(src[47-8*i -: 8]);
      oct.push_back(8'(len / 256));
      oct.push_back(8'(len % 256));
      oct.push_back(8'(typ));
      oct.push_back(dx);
      oct.push_back(dy);
      oct.push_back(8'h00);
      for (int e = 0; e < n; e++) begin
        s = int'(elems_in[k]);
        if (elems_in[k][23]) s = s - (1 << 24);
        v = s;
        k++;
        for (int i = 0; i < 4; i++) oct.push_back(v[31-8*i -: 8]);
      end
      while (oct.size() < PAD_TO) oct.push_back(8'h00);
      nw = (oct.size() + B - 1) / B;
      for (int w = 0; w < nw; w++) begin
        word_t x;
        x = '0;
        for (int b = 0; b < B; b++)
          if (w * B + b < oct.size()) x.data[W-1-8*b -: 8] = oct[w*B+b];
        x.sop   = (w == 0);
        x.eop   = (w == nw - 1);
        x.empty = x.eop ? 2'(nw * B - oct.size()) : 2'd0;
        exp_q.push_back(x);
      end
    end while (rem > 0);
  endtask

  task automatic fill_random(input int count);
    elems_in.delete();
    repeat (count) elems_in.push_back(24'($urandom));
  endtask

  task automatic start_result(input logic [7:0] dx, input logic [7:0] dy,
                              input logic de, input logic [7:0] rxe);
    int cyc = 0;
    while (!tx_idle && cyc < 10000) begin @(negedge clk); cyc++; end
    check("idle_before_start", 64'(tx_idle), 64'd1);
    model_push(dx, dy, de, rxe);
    elem_q.delete();
    if (rxe == 0 && !de && dx != 0 && dy != 0)
      foreach (elems_in[i]) elem_q.push_back(elems_in[i]);
    dim_x = dx; dim_y = dy; dim_error = de; rx_error = rxe; host_mac = HOST;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    while ((exp_q.size() != 0 || !tx_idle) && cyc < 10000) begin @(negedge clk); cyc++; end
    check({tag, "_all_words"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_all_elems"}, 64'(elem_q.size()), 64'd0);
    exp_q.delete();
    elem_q.delete();
  endtask

  // Sink backpressure.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      tx_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Element source with random gaps.
  initial begin
    bit took;
    res_valid = 1'b0;
    res_data  = '0;
    forever begin
      @(negedge clk);
      took = res_valid && res_ready && !rst;
      @(posedge clk); #2;
      if (took && elem_q.size() != 0) elem_q.delete(0);
      if (elem_q.size() != 0 && $urandom_range(0, 99) < 75) begin
        res_valid = 1'b1;
        res_data  = elem_q[0];
      end else begin
        res_valid = 1'b0;
        res_data  = '0;
      end
    end
  end

  // Single compare process: every transferred word against the model,
  // and output stability across every stalled cycle.
  word_t prev_w;
  bit    stall_prev = 1'b0;
  always @(negedge clk) begin
    word_t cur, e;
    cur = {tx_sop, tx_eop, tx_empty, tx_data};
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check("stall_hold", 64'({tx_valid, cur}), 64'({1'b1, prev_w}));
      if (tx_valid && tx_ready) begin
        rx_words.push_back(cur);
        check("word_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check($sformatf("word%0d", rx_words.size() - 1), 64'(cur), 64'(e));
        end
      end
      stall_prev = tx_valid && !tx_ready;
      prev_w     = cur;
    end
  end

  initial begin
    int mism;
    rst = 1'b1; start = 1'b0; dim_x = '0; dim_y = '0; dim_error = 1'b0;
    rx_error = '0; host_mac = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({tx_valid, tx_sop, tx_eop, res_ready, tx_data, tx_empty, tx_idle}),
          64'({4'b0000, 32'h0, 2'b00, 1'b1}));
    rst = 1'b0;
    @(negedge clk);

    // 1: 3x2, elements 1..6
    rx_words.delete();
    elems_in.delete();
    for (int i = 1; i <= 6; i++) elems_in.push_back(24'(i));
    start_result(8'd3, 8'd2, 1'b0, 8'h00);
    wait_done("t1");
    check("t1_words", 64'(rx_words.size()), 64'(exp_words(42)));
    check("t1_len_type_dx", 64'(rx_at(3).data), 64'h001C_0103);
    check("t1_dy_rsvd", 64'(rx_at(4).data[31:16]), 64'h0200);
    check("t1_elem1", 64'(rx_at(5).data), 64'h0001_0000);
    check("t1_elem6", 64'(rx_at(10).data), 64'h0006_0000);
    check("t1_last", 64'({rx_at(exp_words(42) - 1).eop, rx_at(exp_words(42) - 1).empty}),
          64'({1'b1, 2'(exp_empty(42))}));

    // 2: negative element sign-extension
    rx_words.delete();
    elems_in.delete();
    elems_in.push_back(24'hFF_FFFB);
    start_result(8'd1, 8'd1, 1'b0, 8'h00);
    wait_done("t2");
    check("t2_elem_hi", 64'(rx_at(4).data), 64'h0100_FFFF);
    check("t2_elem_lo", 64'(rx_at(5).data[31:16]), 64'hFFFB);

    // 3: 20x20 splits into 368 + 32 elements
    rx_words.delete();
    fill_random(400);
    start_result(8'd20, 8'd20, 1'b0, 8'h00);
    wait_done("t3");
    t3_words = rx_words;
    check("t3_words", 64'(rx_words.size()), 64'd410);
    check("t3_f1_hdr", 64'(rx_at(3).data), 64'h05C4_0114);
    check("t3_f1_eop", 64'({rx_at(372).eop, rx_at(372).empty}), 64'({1'b1, 2'd2}));
    check("t3_f2_sop", 64'(rx_at(373).sop), 64'd1);
    check("t3_f2_hdr", 64'(rx_at(376).data), 64'h0084_0114);
    check("t3_f2_dy", 64'(rx_at(377).data[31:24]), 64'h14);

    // 4: rx error outranks dimension error
    rx_words.delete();
    start_result(8'd5, 8'd6, 1'b1, 8'h01);
    wait_done("t4");
    check("t4_words", 64'(rx_words.size()), 64'(exp_words(18)));
    check("t4_hdr", 64'(rx_at(3).data), 64'h0004_0405);
    check("t4_dy", 64'(rx_at(4).data), 64'h0600_0000);
    check("t4_last", 64'({rx_at(exp_words(18) - 1).eop, rx_at(exp_words(18) - 1).empty}),
          64'({1'b1, 2'(exp_empty(18))}));

    // 5: case 3 under 50% backpressure, plus a start while busy
    rx_words.delete();
    ready_pct = 50;
    start_result(8'd20, 8'd20, 1'b0, 8'h00);
    repeat (100) @(negedge clk);
    dim_x = 8'd1; dim_y = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t5");
    mism = 0;
    foreach (t3_words[i]) if (rx_at(i) !== t3_words[i]) mism++;
    check("t5_same_as_t3", 64'(mism + rx_words.size()), 64'(t3_words.size()));

    // Randomised requests, including zero dims and error flags
    ready_pct = 60;
    for (int it = 0; it < 6; it++) begin
      logic [7:0] dx, dy, rxe;
      logic       de;
      dx  = 8'($urandom_range(0, 5));
      dy  = 8'($urandom_range(0, 5));
      de  = ($urandom_range(0, 7) == 0);
      rxe = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      fill_random(dx * dy);
      start_result(dx, dy, de, rxe);
      wait_done($sformatf("rnd%0d", it));
    end

    // 6: reset mid-payload, then a fresh frame
    ready_pct = 100;
    fill_random(400);
    start_result(8'd20, 8'd20, 1'b0, 8'h00);
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    elem_q.delete();
    @(negedge clk);
    check("t6_after_rst", 64'({tx_valid, tx_idle, res_ready}), 64'(3'b010));
    rst = 1'b0;
    @(negedge clk);
    rx_words.delete();
    fill_random(4);
    start_result(8'd2, 8'd2, 1'b0, 8'h00);
    wait_done("t6");
    check("t6_words", 64'(rx_words.size()), 64'(exp_words(34)));
    check("t6_hdr", 64'(rx_at(3).data), 64'h0014_0102);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
